// File: rtl/vga_sync_recover.sv
// vga_sync_recover: recovers raster coordinates from an active-low h_sync/v_sync pair.
// Ports: clk/Reset (synchronous, active-low); h_sync/v_sync in; h_pos/v_pos, active, locked,
//   line_len (last h-sync period) and err (one-cycle bad-period pulse while locked) out.
// Option: define VGA_SYNC_RECOVER_INPUT_SYNC_EN to add a two-flop input synchronizer (+2 cycles).
module vga_sync_recover #(
  parameter int H_TOTAL    = 840,
  parameter int H_ACTIVE   = 640,
  parameter int H_SYNC_POS = 655,
  parameter int V_TOTAL    = 500,
  parameter int V_ACTIVE   = 480,
  parameter int V_SYNC_POS = 480,
  parameter int H_TOL      = 1,
  parameter int LOCK_LINES = 8,
  parameter int MISS_MAX   = 4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        h_sync,
  input  logic        v_sync,
  output logic [9:0]  h_pos,
  output logic [9:0]  v_pos,
  output logic        active,
  output logic        locked,
  output logic [10:0] line_len,
  output logic        err
);

`ifdef VGA_SYNC_RECOVER_INPUT_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  localparam int GW = $clog2(LOCK_LINES + 1);
  localparam int MW = $clog2(MISS_MAX + 1);

  localparam logic [10:0] PER_MIN = 11'(H_TOTAL);
  localparam logic [10:0] PER_MAX = 11'(H_TOTAL + H_TOL);
  localparam logic [10:0] CNT_TO  = 11'(2 * H_TOTAL);
  localparam logic [10:0] CNT_SAT = 11'h7ff;
  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  // The load lands one clock after the sync sample (plus synchronizer delay),
  // so it is pre-advanced to line up with the generator's counter.
  localparam logic [9:0]  H_LOAD  = 10'(H_SYNC_POS + 1 + SL);
  localparam logic [9:0]  V_LOAD  = 10'(V_SYNC_POS);
  localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  localparam logic [GW-1:0] LOCK_G = GW'(LOCK_LINES);
  localparam logic [MW-1:0] MISS_G = MW'(MISS_MAX);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t        state;
  logic          h_in, v_in;
  logic          h_prev, v_prev;
  logic [10:0]   cnt;
  logic [GW-1:0] good_cnt;
  logic [MW-1:0] miss_cnt;
  logic          v_seen;

  logic          h_edge, v_edge, period_good, timeout, h_wrap, v_wrap;
  logic [GW-1:0] good_new;
  logic          seen_new;
  logic [MW-1:0] miss_inc;

`ifdef VGA_SYNC_RECOVER_INPUT_SYNC_EN
  logic [1:0] h_meta, v_meta;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      h_meta <= 2'b11;
      v_meta <= 2'b11;
    end else begin
      h_meta <= {h_meta[0], h_sync};
      v_meta <= {v_meta[0], v_sync};
    end
  end

  assign h_in = h_meta[1];
  assign v_in = v_meta[1];
`else
  assign h_in = h_sync;
  assign v_in = v_sync;
`endif

  assign h_edge      = h_prev & ~h_in;
  assign v_edge      = v_prev & ~v_in;
  assign period_good = (cnt >= PER_MIN) && (cnt <= PER_MAX);
  // Counter value 2*H_TOTAL means that many clocks since the last h edge.
  assign timeout     = (cnt == CNT_TO) && !h_edge;
  assign h_wrap      = (h_pos == H_LAST);
  assign v_wrap      = (v_pos == V_LAST);
  assign miss_inc    = miss_cnt + MW'(1);

  // Acquisition bookkeeping for this cycle; good_cnt saturates at LOCK_LINES
  // so a late v edge can still complete the lock.
  assign good_new = !h_edge     ? good_cnt :
                    !period_good ? '0 :
                    (good_cnt == LOCK_G) ? good_cnt : good_cnt + GW'(1);
  assign seen_new = v_seen | v_edge;

  assign active = locked & (h_pos < H_ACT) & (v_pos < V_ACT);

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state    <= SEARCH;
      h_prev   <= 1'b1;
      v_prev   <= 1'b1;
      cnt      <= '0;
      line_len <= '0;
      h_pos    <= '0;
      v_pos    <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
      good_cnt <= '0;
      miss_cnt <= '0;
      v_seen   <= 1'b0;
    end else begin
      h_prev <= h_in;
      v_prev <= v_in;
      err    <= 1'b0;

      if (h_edge) begin
        cnt      <= 11'd1;
        line_len <= cnt;
      end else if (cnt != CNT_SAT) begin
        cnt <= cnt + 11'd1;
      end

      if (h_edge)      h_pos <= H_LOAD;
      else if (h_wrap) h_pos <= '0;
      else             h_pos <= h_pos + 10'd1;

      // A wrap overridden by an h-edge load is not a line boundary.
      if (v_edge)                v_pos <= V_LOAD;
      else if (h_wrap && !h_edge) v_pos <= v_wrap ? '0 : v_pos + 10'd1;

      case (state)
        SEARCH: begin
          locked   <= 1'b0;
          good_cnt <= '0;
          miss_cnt <= '0;
          v_seen   <= 1'b0;
          if (h_edge) state <= ACQUIRE;
        end
        ACQUIRE: begin
          if (timeout) begin
            state <= SEARCH;
          end else begin
            good_cnt <= good_new;
            v_seen   <= seen_new;
            if (good_new == LOCK_G && seen_new) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              miss_cnt <= '0;
            end
          end
        end
        LOCKED: begin
          if (h_edge) begin
            if (period_good) begin
              miss_cnt <= '0;
            end else begin
              err <= 1'b1;
              if (miss_inc == MISS_G) begin
                state  <= SEARCH;
                locked <= 1'b0;
              end else begin
                miss_cnt <= miss_inc;
              end
            end
          end else if (timeout) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_recover.sv
// Directed bench for vga_sync_recover: drives a raster from a small generator
// model and checks lock timing, coordinates, error pulses, timeout and reset.
module tb_vga_sync_recover;

`ifdef VGA_SYNC_RECOVER_INPUT_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  localparam int VT = 500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs, vs;
  logic [9:0]  h_pos, v_pos;
  logic        active, locked, err;
  logic [10:0] line_len;

  always #5 clk = ~clk;

  vga_sync_recover dut (
    .clk(clk), .Reset(rst_n), .h_sync(hs), .v_sync(vs),
    .h_pos(h_pos), .v_pos(v_pos), .active(active), .locked(locked),
    .line_len(line_len), .err(err)
  );

  int n_chk = 0;
  int n_err = 0;
  int hc, vc, hlen, next_len, jump_v;
  bit jump_pending, hold_high, chk, lock_seen;
  int coord_bad, err_n, first_err_hc, cyc, t0;
  logic err_lock [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: advance the generator, observe the DUT, drive the new sync levels.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (hc >= hlen - 1) begin
      hc   = 0;
      hlen = next_len;
      if (jump_pending) begin
        vc = jump_v;
        jump_pending = 1'b0;
      end else begin
        vc = (vc == VT - 1) ? 0 : vc + 1;
      end
    end else begin
      hc++;
    end
    if (chk) begin
      if (h_pos !== 10'(hc) || v_pos !== 10'(vc) || active !== (hc < 640 && vc < 480))
        coord_bad++;
    end
    if (locked === 1'b1) lock_seen = 1'b1;
    if (err === 1'b1) begin
      if (err_n == 0) first_err_hc = hc;
      if (err_n < 8) err_lock[err_n] = locked;
      err_n++;
    end
    hs = hold_high ? 1'b1 : !(hc >= 655 && hc < 751);
    vs = !(vc >= 480 && vc < 482);
  endtask

  task automatic goto_line_start();
    int n = 0;
    do begin
      tick();
      n++;
    end while (hc != 0 && n < 2000);
  endtask

  task automatic wait_lock(input int exp_h);
    int n = 0;
    while (locked !== 1'b1 && n < 15000) begin
      tick();
      n++;
    end
    check("lock_rise", locked, 1);
    check("lock_h", hc, exp_h);
    check("lock_v", vc, 480);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; hs = 1'b1; vs = 1'b1;
    hc = 839; vc = 469; hlen = 840; next_len = 840;
    jump_pending = 0; hold_high = 0; chk = 0; lock_seen = 0;
    coord_bad = 0; err_n = 0; first_err_hc = -1; cyc = 0; jump_v = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_h_pos", h_pos, 0);
    check("rst_v_pos", v_pos, 0);
    check("rst_active", active, 0);
    check("rst_locked", locked, 0);
    check("rst_line_len", line_len, 0);
    check("rst_err", err, 0);

    // Nominal raster from line 470: lock on the v edge after 8+ good lines
    rst_n = 1'b1;
    wait_lock(1 + SL);
    chk = 1; coord_bad = 0; err_n = 0; n = 0;
    while (!(vc == 1 && hc == 700) && n < 25000) begin
      tick();
      n++;
    end
    chk = 0;
    check("coords_track", coord_bad, 0);
    check("nom_line_len", line_len, 840);
    check("nom_no_err", err_n, 0);
    check("active_hblank", active, 0);

    // One 830-clock line while locked
    err_n = 0; first_err_hc = -1;
    goto_line_start();
    hlen = 830;
    n = 0;
    while (err_n == 0 && n < 3000) begin
      tick();
      n++;
    end
    check("err_pos", first_err_hc, 656 + SL);
    check("short_line_len", line_len, 830);
    repeat (1700) tick();
    check("err_single", err_n, 1);
    check("locked_after_bad", locked, 1);

    // One-clock reset mid-frame, then relock from scratch
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_h_pos", h_pos, 0);
    check("mid_rst_v_pos", v_pos, 0);
    check("mid_rst_active", active, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_line_len", line_len, 0);
    check("mid_rst_err", err, 0);
    jump_v = 470; jump_pending = 1;
    wait_lock(1 + SL);

    // Hold h_sync high while locked: timeout 1680 clocks after the last edge
    err_n = 0; n = 0;
    while (hc != 656 + SL && n < 2000) begin
      tick();
      n++;
    end
    t0 = cyc;
    hold_high = 1;
    n = 0;
    while (locked === 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check("timeout_delay", cyc - t0, 1680);
    check("timeout_locked", locked, 0);
    check("timeout_no_err", err_n, 0);
    hold_high = 0;
    jump_v = 470; jump_pending = 1;
    wait_lock(1 + SL);

    // Four consecutive 830-clock lines: lock drops with the 4th err
    err_n = 0;
    for (int i = 0; i < 4; i++) begin
      goto_line_start();
      hlen = 830;
    end
    n = 0;
    while (err_n < 4 && n < 3000) begin
      tick();
      n++;
    end
    check("drop_locked_3rd", err_lock[2], 1);
    check("drop_locked_4th", err_lock[3], 0);
    repeat (900) tick();
    check("drop_err_count", err_n, 4);
    check("drop_locked", locked, 0);

    // All lines 845 clocks: never locks, never errs
    next_len = 845; err_n = 0; lock_seen = 0;
    jump_v = 470; jump_pending = 1;
    repeat (12 * 845) tick();
    check("long_no_lock", lock_seen, 0);
    check("long_no_err", err_n, 0);
    check("long_line_len", line_len, 845);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
